// File: rtl/irq_nest_controller.sv
// Nested vectored interrupt controller for the single-cycle RISC-V core.
// Latches rising edges on three request lines and picks the highest-priority
// pending one. If it outranks the running handler, the PC is redirected to
// that handler's vector and the return PC is pushed on a 3-entry stack.
// uret pops the stack and redirects the PC to the saved return address.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal execution; an interrupt may be accepted or uret popped
// ST_GUARD | one cycle after a redirect; lets the first target instr commit
module irq_nest_controller #(
  parameter logic [31:0] VEC0  = 32'h0000_1000,
  parameter logic [31:0] VEC1  = 32'h0000_1100,
  parameter logic [31:0] VEC2  = 32'h0000_1200,
  parameter int          DEPTH = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  irq_req,
  input  logic [31:0] pc_next,
  input  logic        uret,
  input  logic        halt,
  input  logic        ie_set,
  input  logic        ie_clr,
  output logic        int_redirect,
  output logic [31:0] int_target,
  output logic [2:0]  pending,
  output logic [1:0]  cur_level,
  output logic [1:0]  depth,
  output logic        ie,
  output logic        uret_err
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  irq_prev;
  logic [2:0]  rise;
  logic [2:0]  clr_mask;

  logic [31:0] stk_pc  [DEPTH];
  logic [1:0]  stk_lvl [DEPTH];
  logic [31:0] top_pc;
  logic [1:0]  top_lvl;

  logic        have_req;
  logic [1:0]  win_idx;
  logic [1:0]  win_lvl;
  logic [31:0] win_vec;

  logic        accept;
  logic        pop;

  assign rise    = irq_req & ~irq_prev;
  assign win_lvl = win_idx + 2'd1;

  // Fixed-priority pick of the highest pending request and its vector.
  always_comb begin
    have_req = 1'b0;
    win_idx  = 2'd0;
    win_vec  = VEC0;
    if (pending[2]) begin
      have_req = 1'b1;
      win_idx  = 2'd2;
      win_vec  = VEC2;
    end else if (pending[1]) begin
      have_req = 1'b1;
      win_idx  = 2'd1;
      win_vec  = VEC1;
    end else if (pending[0]) begin
      have_req = 1'b1;
      win_idx  = 2'd0;
      win_vec  = VEC0;
    end
  end

  // Top-of-stack view; only meaningful while depth is non-zero.
  always_comb begin
    top_pc  = 32'h0;
    top_lvl = 2'd0;
    case (depth)
      2'd1: begin
        top_pc  = stk_pc[0];
        top_lvl = stk_lvl[0];
      end
      2'd2: begin
        top_pc  = stk_pc[1];
        top_lvl = stk_lvl[1];
      end
      2'd3: begin
        top_pc  = stk_pc[2];
        top_lvl = stk_lvl[2];
      end
      default: begin
        top_pc  = 32'h0;
        top_lvl = 2'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and redirect decision; uret outranks a new interrupt.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    pop          = 1'b0;
    uret_err     = 1'b0;
    int_redirect = 1'b0;
    int_target   = 32'h0;
    if (!RST) begin
      case (state)
        ST_RUN: begin
          if (uret) begin
            if (depth != 2'd0) begin
              pop          = 1'b1;
              int_redirect = 1'b1;
              int_target   = top_pc;
              state_nxt    = ST_GUARD;
            end else begin
              uret_err = 1'b1;
            end
          end else if (ie && !halt && have_req && (win_lvl > cur_level)) begin
            accept       = 1'b1;
            int_redirect = 1'b1;
            int_target   = win_vec;
            state_nxt    = ST_GUARD;
          end
        end
        ST_GUARD: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Pending bit of the accepted request is cleared; a same-cycle rise is lost.
  always_comb begin
    clr_mask = 3'b000;
    if (accept) begin
      clr_mask = 3'b001 << win_idx;
    end
  end

  // Edge detect, pending latch and interrupt enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_prev <= 3'b000;
      pending  <= 3'b000;
      ie       <= 1'b1;
    end else begin
      irq_prev <= irq_req;
      pending  <= (pending | rise) & ~clr_mask;
      if (ie_clr) begin
        ie <= 1'b0;
      end else if (ie_set) begin
        ie <= 1'b1;
      end
    end
  end

  // Return stack, occupancy and current handler level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_level <= 2'd0;
      depth     <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_pc[i]  <= 32'h0;
        stk_lvl[i] <= 2'd0;
      end
    end else if (pop) begin
      cur_level <= top_lvl;
      depth     <= depth - 2'd1;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth == 2'(i)) begin
          stk_pc[i]  <= pc_next;
          stk_lvl[i] <= cur_level;
        end
      end
      cur_level <= win_lvl;
      depth     <= depth + 2'd1;
    end
  end

  // A push into a full stack is impossible by construction (depth 3 implies
  // level 3); flag it if it ever happens.
  push_when_full: assert property (@(posedge CLK) disable iff (RST)
    !(accept && (depth == 2'(DEPTH))));

endmodule

// File: tb/tb_irq_nest_controller.sv
// Directed bench for irq_nest_controller with a queue-based reference model
// compared on every cycle, plus literal checks at the key points.
module tb_irq_nest_controller;

  logic        CLK;
  logic        RST;
  logic [2:0]  irq_req;
  logic [31:0] pc_next;
  logic        uret;
  logic        halt;
  logic        ie_set;
  logic        ie_clr;
  logic        int_redirect;
  logic [31:0] int_target;
  logic [2:0]  pending;
  logic [1:0]  cur_level;
  logic [1:0]  depth;
  logic        ie;
  logic        uret_err;

  int errors = 0;
  int checks = 0;

  irq_nest_controller dut (
    .CLK          (CLK),
    .RST          (RST),
    .irq_req      (irq_req),
    .pc_next      (pc_next),
    .uret         (uret),
    .halt         (halt),
    .ie_set       (ie_set),
    .ie_clr       (ie_clr),
    .int_redirect (int_redirect),
    .int_target   (int_target),
    .pending      (pending),
    .cur_level    (cur_level),
    .depth        (depth),
    .ie           (ie),
    .uret_err     (uret_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, handler level, return stack as a queue.
  typedef struct {
    logic [31:0] pc;
    int          lvl;
  } ent_t;

  ent_t       m_stk[$];
  logic [2:0] m_pending = 3'b000;
  logic [2:0] m_prev    = 3'b000;
  int         m_level   = 0;
  bit         m_ie      = 1'b1;
  bit         m_guard   = 1'b0;
  bit         m_valid   = 1'b0;

  function automatic int top_req();
    for (int i = 2; i >= 0; i--) begin
      if (m_pending[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_accept();
    int k = top_req();
    return !RST && !m_guard && m_ie && !halt && !uret && (k >= 0) && (k + 1 > m_level);
  endfunction

  function automatic bit m_pop();
    return !RST && !m_guard && uret && (m_stk.size() > 0);
  endfunction

  function automatic bit m_err();
    return !RST && !m_guard && uret && (m_stk.size() == 0);
  endfunction

  function automatic logic [31:0] m_target();
    if (m_pop()) return m_stk[$].pc;
    if (m_accept()) return 32'h1000 + 32'h100 * top_req();
    return 32'h0;
  endfunction

  always @(posedge CLK) begin : model_update
    bit a;
    bit p;
    int k;
    if (RST) begin
      m_stk.delete();
      m_pending = 3'b000;
      m_prev    = 3'b000;
      m_level   = 0;
      m_ie      = 1'b1;
      m_guard   = 1'b0;
      m_valid   = 1'b1;
    end else begin
      a = m_accept();
      p = m_pop();
      k = top_req();
      m_pending = m_pending | (irq_req & ~m_prev);
      m_prev    = irq_req;
      if (a) m_pending[k] = 1'b0;
      if (ie_clr) m_ie = 1'b0;
      else if (ie_set) m_ie = 1'b1;
      if (p) begin
        m_level = m_stk[$].lvl;
        void'(m_stk.pop_back());
        m_guard = 1'b1;
      end else if (a) begin
        m_stk.push_back('{pc: pc_next, lvl: m_level});
        m_level = k + 1;
        m_guard = 1'b1;
      end else begin
        m_guard = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("cmp_redirect", {31'b0, int_redirect}, {31'b0, m_accept() | m_pop()});
      chk("cmp_target",   int_target, m_target());
      chk("cmp_pending",  {29'b0, pending}, {29'b0, m_pending});
      chk("cmp_level",    {30'b0, cur_level}, 32'(m_level));
      chk("cmp_depth",    {30'b0, depth}, 32'(m_stk.size()));
      chk("cmp_ie",       {31'b0, ie}, {31'b0, m_ie});
      chk("cmp_uret_err", {31'b0, uret_err}, {31'b0, m_err()});
    end
  end

  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; irq_req = 3'b000; pc_next = 32'h0; uret = 1'b0;
    halt = 1'b0; ie_set = 1'b0; ie_clr = 1'b0;

    // reset
    mid();
    chk("lit_rst_redirect", {31'b0, int_redirect}, 32'd0);
    chk("lit_rst_target", int_target, 32'h0);
    go(); go();
    mid();
    chk("lit_rst_pending", {29'b0, pending}, 32'd0);
    chk("lit_rst_level", {30'b0, cur_level}, 32'd0);
    chk("lit_rst_depth", {30'b0, depth}, 32'd0);
    chk("lit_rst_ie", {31'b0, ie}, 32'd1);

    // single irq0, then pre-emption by irq2 and two urets
    RST = 1'b0; pc_next = 32'h40; go();
    irq_req = 3'b001;
    mid(); chk("lit_no_early_redirect", {31'b0, int_redirect}, 32'd0);
    go();
    mid();
    chk("lit_irq0_redirect", {31'b0, int_redirect}, 32'd1);
    chk("lit_irq0_target", int_target, 32'h1000);
    go();
    mid();
    chk("lit_irq0_level", {30'b0, cur_level}, 32'd1);
    chk("lit_irq0_depth", {30'b0, depth}, 32'd1);
    chk("lit_irq0_pending", {29'b0, pending}, 32'd0);
    pc_next = 32'h1008; go();
    irq_req = 3'b101; go();
    mid(); chk("lit_irq2_target", int_target, 32'h1200);
    go();
    irq_req = 3'b000;
    mid();
    chk("lit_nest_depth", {30'b0, depth}, 32'd2);
    chk("lit_nest_level", {30'b0, cur_level}, 32'd3);
    go();
    uret = 1'b1;
    mid(); chk("lit_uret1_target", int_target, 32'h1008);
    go();
    mid();
    chk("lit_guard_uret_redirect", {31'b0, int_redirect}, 32'd0);
    chk("lit_guard_uret_err", {31'b0, uret_err}, 32'd0);
    go();
    mid(); chk("lit_uret2_target", int_target, 32'h40);
    go();
    uret = 1'b0;
    mid();
    chk("lit_uret2_level", {30'b0, cur_level}, 32'd0);
    chk("lit_uret2_depth", {30'b0, depth}, 32'd0);
    go();
    uret = 1'b1;
    mid();
    chk("lit_empty_uret_err", {31'b0, uret_err}, 32'd1);
    chk("lit_empty_uret_redirect", {31'b0, int_redirect}, 32'd0);
    go();
    uret = 1'b0;
    mid(); chk("lit_uret_err_pulse", {31'b0, uret_err}, 32'd0);

    // simultaneous rises on irq0 and irq1
    irq_req = 3'b011; pc_next = 32'h80; go();
    mid(); chk("lit_same_target", int_target, 32'h1100);
    go();
    irq_req = 3'b000;
    mid();
    chk("lit_same_pending", {29'b0, pending}, 32'd1);
    chk("lit_same_level", {30'b0, cur_level}, 32'd2);
    go();
    mid(); chk("lit_lower_blocked", {31'b0, int_redirect}, 32'd0);
    go();
    uret = 1'b1;
    mid(); chk("lit_same_uret_target", int_target, 32'h80);
    go();
    uret = 1'b0;
    mid(); chk("lit_same_guard", {31'b0, int_redirect}, 32'd0);
    go();
    mid(); chk("lit_irq0_after_uret", int_target, 32'h1000);
    go(); go();
    uret = 1'b1; go();
    uret = 1'b0; go();

    // uret coinciding with an eligible pending request
    pc_next = 32'hC0; irq_req = 3'b001; go(); go();
    irq_req = 3'b000; go();
    irq_req = 3'b100; go();
    uret = 1'b1;
    mid();
    chk("lit_coinc_target", int_target, 32'hC0);
    chk("lit_coinc_pending", {29'b0, pending}, 32'd4);
    go();
    uret = 1'b0;
    mid(); chk("lit_coinc_guard", {31'b0, int_redirect}, 32'd0);
    go();
    mid(); chk("lit_coinc_late_target", int_target, 32'h1200);
    go();
    irq_req = 3'b000; go();
    uret = 1'b1; go();
    uret = 1'b0; go();

    // interrupt-enable gating
    ie_clr = 1'b1; go();
    ie_clr = 1'b0;
    mid(); chk("lit_ie_cleared", {31'b0, ie}, 32'd0);
    irq_req = 3'b010; go();
    irq_req = 3'b000;
    mid();
    chk("lit_gated_pending", {29'b0, pending}, 32'd2);
    chk("lit_gated_redirect", {31'b0, int_redirect}, 32'd0);
    go();
    ie_set = 1'b1;
    mid(); chk("lit_ie_set_delay", {31'b0, int_redirect}, 32'd0);
    pc_next = 32'h100; go();
    ie_set = 1'b0;
    mid(); chk("lit_ie_target", int_target, 32'h1100);
    go(); go();
    uret = 1'b1; go();
    uret = 1'b0; go();
    ie_set = 1'b1; ie_clr = 1'b1; go();
    ie_set = 1'b0; ie_clr = 1'b0;
    mid(); chk("lit_ie_clr_wins", {31'b0, ie}, 32'd0);
    ie_set = 1'b1; go();
    ie_set = 1'b0;

    // halt gating; uret still honoured while halted
    halt = 1'b1; irq_req = 3'b010; pc_next = 32'h140; go();
    irq_req = 3'b000;
    mid();
    chk("lit_halt_redirect", {31'b0, int_redirect}, 32'd0);
    chk("lit_halt_pending", {29'b0, pending}, 32'd2);
    go();
    halt = 1'b0;
    mid(); chk("lit_unhalt_target", int_target, 32'h1100);
    go();
    halt = 1'b1; uret = 1'b1; go();
    mid(); chk("lit_halt_uret_target", int_target, 32'h140);
    go();
    halt = 1'b0; uret = 1'b0; go();

    // fill the stack, then reset mid-service
    pc_next = 32'h200; irq_req = 3'b001; go(); go(); go();
    irq_req = 3'b011; go(); go(); go();
    irq_req = 3'b111; go(); go();
    mid();
    chk("lit_full_depth", {30'b0, depth}, 32'd3);
    chk("lit_full_level", {30'b0, cur_level}, 32'd3);
    go();
    irq_req = 3'b000; go();
    irq_req = 3'b001; go();
    mid();
    chk("lit_full_pending", {29'b0, pending}, 32'd1);
    chk("lit_full_blocked", {31'b0, int_redirect}, 32'd0);
    RST = 1'b1; uret = 1'b1; irq_req = 3'b000;
    #1;
    mid();
    chk("lit_rst_mid_redirect", {31'b0, int_redirect}, 32'd0);
    chk("lit_rst_mid_target", int_target, 32'h0);
    go();
    RST = 1'b0; uret = 1'b0;
    mid();
    chk("lit_after_rst_level", {30'b0, cur_level}, 32'd0);
    chk("lit_after_rst_depth", {30'b0, depth}, 32'd0);
    chk("lit_after_rst_pending", {29'b0, pending}, 32'd0);
    go(); go();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_nest_controller.md
Name: irq_nest_controller

Overview:
- Nested vectored interrupt controller for the single-cycle RISC-V core; sits beside the main decode controller and the PC register.
- Latches three external interrupt requests and arbitrates them by fixed priority. Redirects the PC to the winning handler and saves the return PC on a 3-deep hardware stack.
- Services decoded uret by popping that stack. Higher-priority requests may pre-empt a running handler.

Parameters:
- VEC0, 32'h0000_1000, handler entry address for irq_req[0] (lowest priority)
- VEC1, 32'h0000_1100, handler entry address for irq_req[1]
- VEC2, 32'h0000_1200, handler entry address for irq_req[2] (highest priority)
- DEPTH, 3, return-stack depth (fixed at 3; one slot per level)

Ports:
- CLK  in  1  system clock. One clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- irq_req  in  3  raw request lines; rising edge = new request
- pc_next  in  32  PC the core would load this cycle without redirect
- uret  in  1  decoded uret of the current instruction (controller output)
- halt  in  1  core halted; blocks acceptance of new interrupts
- ie_set  in  1  CSR write: set global interrupt enable
- ie_clr  in  1  CSR write: clear global interrupt enable
- int_redirect  out  1  PC mux select: load int_target instead of pc_next
- int_target  out  32  redirect address (vector or popped return PC)
- pending  out  3  latched, not yet serviced requests
- cur_level  out  2  0 = no handler running; k+1 = serving irq k
- depth  out  2  stack occupancy, 0..3
- ie  out  1  global interrupt enable
- uret_err  out  1  one-cycle pulse: uret issued with empty stack

Behaviour:
- Reset (sync): pending=0, cur_level=0, depth=0, ie=1, edge-detect regs=0, FSM=RUN, uret_err=0. int_redirect=0 and int_target=0 while RST is high.
- Edge detect:
  - irq_prev <= irq_req every cycle.
  - A rise sets pending[k] (irq_req[k] & ~irq_prev[k]).
  - A held-high line sets pending only once.
- Pending clear: pending[k] clears in the cycle irq k is accepted. A rise on the same line in the same cycle is lost (clear wins). A rise in any other cycle re-sets the bit.
- ie: ie_clr has priority over ie_set when both are high. The update takes effect the next cycle.
- Accept condition (combinational from registered state): FSM=RUN & ie & ~halt & ~uret & the highest set pending bit k satisfies k+1 > cur_level.
- Accept actions:
  - int_redirect=1, int_target=VECk.
  - On the edge: push {pc_next, cur_level} to stack[depth]; depth+1; cur_level <= k+1; clear pending[k]; FSM -> GUARD.
- uret with depth>0:
  - int_redirect=1, int_target=stack[depth-1].pc.
  - On the edge: cur_level <= stack[depth-1].lvl; depth-1; FSM -> GUARD.
- uret with depth=0: no redirect; uret_err pulses for 1 cycle; state unchanged.
- uret and a valid accept in the same cycle: uret wins; the interrupt stays pending and is re-evaluated after GUARD.
- GUARD: lasts exactly one cycle and blocks both accept and uret-pop, so the first handler or return-path instruction commits. uret seen in GUARD is ignored without uret_err. GUARD -> RUN unconditionally.
- Stack full: depth=3 can only occur at cur_level=3, so no further accept is possible. No overflow path exists; an implementation assertion must flag any push at depth=3.
- Latency:
  - Edge on irq_req -> pending visible next cycle.
  - Earliest redirect is the cycle after the rise: pending registered, then combinational accept.
- Lower or equal priority than cur_level: remains pending until cur_level drops below k+1 via uret.
- halt=1: pending still latches; no accept; uret still honoured.
- RST mid-service: stack, level and pending are discarded; no redirect in the reset cycle.

Test Plan:
- Reset, then irq_req=3'b001 rising at cycle 2 with pc_next=32'h40 -> cycle 3 int_redirect=1, int_target=32'h1000. Cycle 4: cur_level=1, depth=1, pending=0.
- Pre-emption: inside irq0 handler (pc_next=32'h1008), pulse irq_req[2] -> redirect to 32'h1200, depth=2, cur_level=3.
  - uret -> target 32'h1008, cur_level=1.
  - Second uret -> target 32'h40, cur_level=0, depth=0.
- Same-cycle rises on irq_req=3'b011 -> irq1 accepted first (target 32'h1100); pending=3'b001 remains.
  - irq0 is not taken until after irq1's uret (level 2 -> 0), then redirects to 32'h1000.
- uret at depth=0 -> int_redirect=0, uret_err=1 for one cycle.
- uret coinciding with an eligible pending request -> the uret redirect is taken; the interrupt is accepted no earlier than 2 cycles later (after GUARD).
- Gating:
  - ie_clr, then pulse irq_req[1] -> pending=3'b010 and no redirect.
  - ie_set -> redirect to 32'h1100 on the cycle after ie rises.
  - Repeat with halt=1 -> no redirect until halt drops.
